// File: rtl/conv2d_pkg.sv
// Shared geometry helpers and FSM state encoding for the conv2d scheduler.
package conv2d_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    BIAS   = 3'd1,
    MAC    = 3'd2,
    WAIT   = 3'd3,
    FINISH = 3'd4
  } state_t;

  // Output spatial size for one dimension.
  function automatic int out_dim(input int in_dim, input int pad, input int k, input int stride);
    return (in_dim + 2 * pad - k) / stride + 1;
  endfunction

  // Bits needed to index n elements, never less than 1.
  function automatic int addr_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/conv2d_scheduler_if.sv
// Op/result handshake between the scheduler (master) and the MAC datapath (slave).
interface conv2d_scheduler_if #(
  parameter int IN_AW  = 8,
  parameter int W_AW   = 7,
  parameter int B_AW   = 2,
  parameter int OUT_AW = 8
);
  logic              op_valid;
  logic              op_ready;
  logic              op_bias;
  logic              op_last;
  logic              op_pad;
  logic [IN_AW-1:0]  in_addr;
  logic [W_AW-1:0]   w_addr;
  logic [B_AW-1:0]   b_addr;
  logic [OUT_AW-1:0] out_addr;
  logic              res_done;

  modport master (
    output op_valid, op_bias, op_last, op_pad, in_addr, w_addr, b_addr, out_addr,
    input  op_ready, res_done
  );

  modport slave (
    input  op_valid, op_bias, op_last, op_pad, in_addr, w_addr, b_addr, out_addr,
    output op_ready, res_done
  );
endinterface

// File: rtl/conv2d_tap_addr.sv
// Combinational tap address generator: maps loop indices to flat input/weight
// addresses and flags taps that fall into the zero-padding border.
module conv2d_tap_addr
  import conv2d_pkg::*;
#(
  parameter int IN_CHANNELS = 3,
  parameter int IN_HEIGHT   = 8,
  parameter int IN_WIDTH    = 8,
  parameter int KERNEL_SIZE = 3,
  parameter int STRIDE      = 1,
  parameter int PADDING     = 1,
  parameter int OC_W        = 2,
  parameter int IC_W        = 2,
  parameter int OH_W        = 3,
  parameter int OW_W        = 3,
  parameter int K_W         = 2,
  parameter int IN_AW       = 8,
  parameter int W_AW        = 7
) (
  input  logic [OC_W-1:0]  oc,
  input  logic [IC_W-1:0]  ic,
  input  logic [OH_W-1:0]  oh,
  input  logic [OW_W-1:0]  ow,
  input  logic [K_W-1:0]   kh,
  input  logic [K_W-1:0]   kw,
  output logic [IN_AW-1:0] in_addr,
  output logic [W_AW-1:0]  w_addr,
  output logic             pad
);

  logic signed [31:0] ih;
  logic signed [31:0] iw;

  // Signed tap coordinates, padding test and flat index arithmetic.
  always_comb begin
    ih      = int'(oh) * STRIDE + int'(kh) - PADDING;
    iw      = int'(ow) * STRIDE + int'(kw) - PADDING;
    pad     = (ih < 0) || (ih >= IN_HEIGHT) || (iw < 0) || (iw >= IN_WIDTH);
    in_addr = pad ? '0 : IN_AW'((int'(ic) * IN_HEIGHT + ih) * IN_WIDTH + iw);
    w_addr  = W_AW'(((int'(oc) * IN_CHANNELS + int'(ic)) * KERNEL_SIZE + int'(kh))
                    * KERNEL_SIZE + int'(kw));
  end

endmodule

// File: rtl/conv2d_scheduler.sv
// Conv2d op sequencer: per output element issues one bias-load op followed by
// IC*K*K MAC ops, waits for the datapath to retire the result, then moves on.
module conv2d_scheduler
  import conv2d_pkg::*;
#(
  parameter int IN_CHANNELS  = 3,
  parameter int IN_HEIGHT    = 8,
  parameter int IN_WIDTH     = 8,
  parameter int OUT_CHANNELS = 4,
  parameter int KERNEL_SIZE  = 3,
  parameter int STRIDE       = 1,
  parameter int PADDING      = 1,
  parameter int OUT_HEIGHT   = out_dim(IN_HEIGHT, PADDING, KERNEL_SIZE, STRIDE),
  parameter int OUT_WIDTH    = out_dim(IN_WIDTH, PADDING, KERNEL_SIZE, STRIDE),
  parameter int IN_AW        = addr_w(IN_CHANNELS * IN_HEIGHT * IN_WIDTH),
  parameter int W_AW         = addr_w(OUT_CHANNELS * IN_CHANNELS * KERNEL_SIZE * KERNEL_SIZE),
  parameter int B_AW         = addr_w(OUT_CHANNELS),
  parameter int OUT_AW       = addr_w(OUT_CHANNELS * OUT_HEIGHT * OUT_WIDTH)
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  output logic busy,
  output logic done,
  conv2d_scheduler_if.master bus
);

  localparam int OC_W = addr_w(OUT_CHANNELS);
  localparam int IC_W = addr_w(IN_CHANNELS);
  localparam int OH_W = addr_w(OUT_HEIGHT);
  localparam int OW_W = addr_w(OUT_WIDTH);
  localparam int K_W  = addr_w(KERNEL_SIZE);

  localparam logic [OC_W-1:0] OC_LAST = OC_W'(OUT_CHANNELS - 1);
  localparam logic [IC_W-1:0] IC_LAST = IC_W'(IN_CHANNELS - 1);
  localparam logic [OH_W-1:0] OH_LAST = OH_W'(OUT_HEIGHT - 1);
  localparam logic [OW_W-1:0] OW_LAST = OW_W'(OUT_WIDTH - 1);
  localparam logic [K_W-1:0]  K_LAST  = K_W'(KERNEL_SIZE - 1);

  state_t state, state_next;

  logic [OC_W-1:0]  oc;
  logic [IC_W-1:0]  ic;
  logic [OH_W-1:0]  oh;
  logic [OW_W-1:0]  ow;
  logic [K_W-1:0]   kh;
  logic [K_W-1:0]   kw;

  logic             op_fire;
  logic             mac_last;
  logic             elem_last;
  logic [IN_AW-1:0] tap_in_addr;
  logic [W_AW-1:0]  tap_w_addr;
  logic             tap_pad;

  assign op_fire   = ((state == BIAS) || (state == MAC)) && bus.op_ready;
  assign mac_last  = (ic == IC_LAST) && (kh == K_LAST) && (kw == K_LAST);
  assign elem_last = (oc == OC_LAST) && (oh == OH_LAST) && (ow == OW_LAST);

  conv2d_tap_addr #(
    .IN_CHANNELS (IN_CHANNELS),
    .IN_HEIGHT   (IN_HEIGHT),
    .IN_WIDTH    (IN_WIDTH),
    .KERNEL_SIZE (KERNEL_SIZE),
    .STRIDE      (STRIDE),
    .PADDING     (PADDING),
    .OC_W        (OC_W),
    .IC_W        (IC_W),
    .OH_W        (OH_W),
    .OW_W        (OW_W),
    .K_W         (K_W),
    .IN_AW       (IN_AW),
    .W_AW        (W_AW)
  ) u_tap (
    .oc      (oc),
    .ic      (ic),
    .oh      (oh),
    .ow      (ow),
    .kh      (kh),
    .kw      (kw),
    .in_addr (tap_in_addr),
    .w_addr  (tap_w_addr),
    .pad     (tap_pad)
  );

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  // Next-state and control outputs.
  always_comb begin
    state_next   = state;
    busy         = 1'b0;
    done         = 1'b0;
    bus.op_valid = 1'b0;
    bus.op_bias  = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) state_next = BIAS;
      end
      BIAS: begin
        busy         = 1'b1;
        bus.op_valid = 1'b1;
        bus.op_bias  = 1'b1;
        if (op_fire) state_next = MAC;
      end
      MAC: begin
        busy         = 1'b1;
        bus.op_valid = 1'b1;
        if (op_fire && mac_last) state_next = WAIT;
      end
      WAIT: begin
        busy = 1'b1;
        if (bus.res_done) state_next = elem_last ? FINISH : BIAS;
      end
      FINISH: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Loop counters: kw fastest then kh then ic per element; ow fastest then oh then oc per pass.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      oc <= '0; ic <= '0; oh <= '0; ow <= '0; kh <= '0; kw <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            oc <= '0; ic <= '0; oh <= '0; ow <= '0; kh <= '0; kw <= '0;
          end
        end
        BIAS: begin
          if (op_fire) begin
            ic <= '0; kh <= '0; kw <= '0;
          end
        end
        MAC: begin
          if (op_fire) begin
            if (kw == K_LAST) begin
              kw <= '0;
              if (kh == K_LAST) begin
                kh <= '0;
                ic <= (ic == IC_LAST) ? '0 : ic + 1'b1;
              end else begin
                kh <= kh + 1'b1;
              end
            end else begin
              kw <= kw + 1'b1;
            end
          end
        end
        WAIT: begin
          if (bus.res_done) begin
            if (ow == OW_LAST) begin
              ow <= '0;
              if (oh == OH_LAST) begin
                oh <= '0;
                oc <= (oc == OC_LAST) ? '0 : oc + 1'b1;
              end else begin
                oh <= oh + 1'b1;
              end
            end else begin
              ow <= ow + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Operand fields depend only on state and counters, so they hold while stalled.
  assign bus.op_last  = (state == MAC) && mac_last;
  assign bus.op_pad   = (state == MAC) && tap_pad;
  assign bus.in_addr  = (state == MAC) ? tap_in_addr : '0;
  assign bus.w_addr   = (state == MAC) ? tap_w_addr : '0;
  assign bus.b_addr   = B_AW'(oc);
  assign bus.out_addr = OUT_AW'((int'(oc) * OUT_HEIGHT + int'(oh)) * OUT_WIDTH + int'(ow));

endmodule

// File: tb/tb_conv2d_scheduler.sv
// Directed bench for conv2d_scheduler: default geometry and a STRIDE=2 instance.
module tb_conv2d_scheduler;
  import conv2d_pkg::*;

  logic clk      = 1'b0;
  logic rst      = 1'b1;
  logic start_a  = 1'b0;
  logic start_b  = 1'b0;
  logic op_ready = 1'b0;
  logic res_done = 1'b0;
  logic busy_a, done_a, busy_b, done_b;
  logic sel = 1'b0;

  always #5 clk = ~clk;

  conv2d_scheduler_if #(
    .IN_AW(addr_w(192)), .W_AW(addr_w(108)), .B_AW(addr_w(4)), .OUT_AW(addr_w(256))
  ) bus_a ();
  conv2d_scheduler_if #(
    .IN_AW(addr_w(192)), .W_AW(addr_w(108)), .B_AW(addr_w(4)), .OUT_AW(addr_w(64))
  ) bus_b ();

  assign bus_a.op_ready = op_ready;
  assign bus_a.res_done = res_done;
  assign bus_b.op_ready = op_ready;
  assign bus_b.res_done = res_done;

  conv2d_scheduler dut_a (
    .clk(clk), .rst(rst), .start(start_a), .busy(busy_a), .done(done_a), .bus(bus_a)
  );

  conv2d_scheduler #(.STRIDE(2)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .busy(busy_b), .done(done_b), .bus(bus_b)
  );

  logic       o_valid, o_bias, o_last, o_pad, o_busy, o_done;
  logic [8:0] o_in;
  logic [9:0] o_w;
  logic [1:0] o_b;
  logic [7:0] o_out;

  always_comb begin
    if (sel) begin
      o_valid = bus_b.op_valid; o_bias = bus_b.op_bias; o_last = bus_b.op_last;
      o_pad = bus_b.op_pad; o_busy = busy_b; o_done = done_b;
      o_in = 9'(bus_b.in_addr); o_w = 10'(bus_b.w_addr); o_b = bus_b.b_addr;
      o_out = 8'(bus_b.out_addr);
    end else begin
      o_valid = bus_a.op_valid; o_bias = bus_a.op_bias; o_last = bus_a.op_last;
      o_pad = bus_a.op_pad; o_busy = busy_a; o_done = done_a;
      o_in = 9'(bus_a.in_addr); o_w = 10'(bus_a.w_addr); o_b = bus_a.b_addr;
      o_out = bus_a.out_addr;
    end
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  function automatic logic [31:0] pack(input bit b, input bit l, input bit p,
                                       input int ia, input int wa, input int ba, input int oa);
    return {b, l, p, 9'(ia), 10'(wa), 2'(ba), 8'(oa)};
  endfunction

  logic [31:0] exp_q[$];

  // Reference handshake sequence built from the conv2d loop nest.
  task automatic build_expected(input int stride_v);
    int ohw;
    ohw = (8 + 2 - 3) / stride_v + 1;
    exp_q.delete();
    for (int oc = 0; oc < 4; oc++)
      for (int oh = 0; oh < ohw; oh++)
        for (int ow = 0; ow < ohw; ow++) begin
          int oa;
          oa = (oc * ohw + oh) * ohw + ow;
          exp_q.push_back(pack(1'b1, 1'b0, 1'b0, 0, 0, oc, oa));
          for (int ic = 0; ic < 3; ic++)
            for (int kh = 0; kh < 3; kh++)
              for (int kw = 0; kw < 3; kw++) begin
                int ih, iw, ia, wa;
                bit pd, lst;
                ih  = oh * stride_v + kh - 1;
                iw  = ow * stride_v + kw - 1;
                pd  = (ih < 0) || (ih >= 8) || (iw < 0) || (iw >= 8);
                ia  = pd ? 0 : ic * 64 + ih * 8 + iw;
                wa  = ((oc * 3 + ic) * 3 + kh) * 3 + kw;
                lst = (ic == 2) && (kh == 2) && (kw == 2);
                exp_q.push_back(pack(1'b0, lst, pd, ia, wa, oc, oa));
              end
        end
  endtask

  task automatic run_pass(input int stride_v, input bit stall_en, input int stop_at);
    int hs_idx = 0, n_bias = 0, n_mac = 0, n_done = 0, cyc = 0, n_out;
    int seq_err = 0, stall_err = 0, busy_err = 0, order_err = 0, post_done = 0;
    bit pending = 0, stalled = 0, stopped = 0;
    logic [31:0] word, snap;
    snap = '0;
    build_expected(stride_v);
    n_out = exp_q.size() / 28;
    @(negedge clk);
    res_done = 1'b0;
    op_ready = 1'b1;
    if (sel) start_b = 1'b1; else start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    start_b = 1'b0;
    while (n_done == 0 && !stopped && cyc < 30000) begin
      cyc++;
      op_ready = stall_en ? 1'($urandom_range(0, 1)) : 1'b1;
      res_done = pending;
      pending  = 1'b0;
      word = pack(o_bias, o_last, o_pad, int'(o_in), int'(o_w), int'(o_b), int'(o_out));
      if (stalled && (!o_valid || word !== snap)) stall_err++;
      stalled = o_valid && !op_ready;
      snap    = word;
      if (o_done) begin
        n_done++;
        if (o_busy) busy_err++;
      end
      if (stop_at >= 0 && o_valid && !o_bias && int'(o_out) == stop_at) begin
        stopped = 1'b1;
      end else if (o_valid && op_ready) begin
        if (hs_idx < exp_q.size()) begin
          if (word !== exp_q[hs_idx]) seq_err++;
        end else begin
          seq_err++;
        end
        if (o_bias) begin
          if (int'(o_out) != n_bias) order_err++;
          n_bias++;
        end else begin
          n_mac++;
        end
        if (stride_v == 1 && !stall_en) begin
          case (hs_idx)
            0:  begin check("first_op_bias", o_bias, 1); check("first_op_b_addr", o_b, 0); end
            1:  begin check("mac1_pad", o_pad, 1); check("mac1_in_addr", o_in, 0);
                      check("mac1_w_addr", o_w, 0); end
            5:  begin check("mac5_pad", o_pad, 0); check("mac5_in_addr", o_in, 0);
                      check("mac5_w_addr", o_w, 4); end
            26: check("mac26_last", o_last, 0);
            27: begin check("mac27_last", o_last, 1); check("mac27_w_addr", o_w, 26);
                      check("mac27_in_addr", o_in, 137); end
            default: ;
          endcase
        end
        if (stride_v == 2 && hs_idx == 141) begin
          check("s2_e5_out_addr", o_out, 5);
          check("s2_e5_pad", o_pad, 0);
          check("s2_e5_in_addr", o_in, 9);
        end
        pending = o_last;
        hs_idx++;
      end
      if (n_done == 0 && !stopped) @(negedge clk);
    end
    if (stopped) return;
    check("timeout", (cyc >= 30000) ? 1 : 0, 0);
    check("bias_count", n_bias, n_out);
    check("mac_count", n_mac, n_out * 27);
    check("hs_total", hs_idx, exp_q.size());
    check("seq_mismatches", seq_err, 0);
    check("out_addr_order", order_err, 0);
    check("busy_at_done", busy_err, 0);
    if (stall_en) check("stall_stability", stall_err, 0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (o_done) post_done++;
      if (o_busy) busy_err++;
    end
    check("done_pulses", n_done + post_done, 1);
    check("busy_after_done", busy_err, 0);
  endtask

  initial begin
    int late_done;
    #2 rst = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_busy", o_busy, 0);
    check("rst_done", o_done, 0);
    check("rst_op_valid", o_valid, 0);
    check("rst_op_bias", o_bias, 0);
    check("rst_op_last", o_last, 0);
    check("rst_op_pad", o_pad, 0);
    check("rst_in_addr", o_in, 0);
    check("rst_w_addr", o_w, 0);
    check("rst_b_addr", o_b, 0);
    check("rst_out_addr", o_out, 0);
    @(negedge clk);
    rst = 1'b1;

    sel = 1'b0;
    run_pass(1, 1'b0, -1);
    run_pass(1, 1'b1, -1);
    sel = 1'b1;
    run_pass(2, 1'b0, -1);

    sel = 1'b0;
    run_pass(1, 1'b0, 10);
    check("abort_in_mac", (o_valid && !o_bias) ? 1 : 0, 1);
    check("abort_elem", o_out, 10);
    #2 rst = 1'b0;
    #1;
    check("abort_op_valid", o_valid, 0);
    check("abort_busy", o_busy, 0);
    check("abort_out_addr", o_out, 0);
    check("abort_op_pad", o_pad, 0);
    check("abort_in_addr", o_in, 0);
    late_done = 0;
    res_done = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (o_done) late_done++;
    end
    check("abort_no_done", late_done, 0);
    rst = 1'b1;
    run_pass(1, 1'b0, -1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/conv2d_scheduler.md
Name: conv2d_scheduler

Overview:
Sequencer for a single shared multiply-accumulate datapath that computes the conv2d layer (NCHW, batch 1) over the flat input, weight and bias tensors. On start it walks every output element (oc, oh, ow). For each element it issues one bias-load op and then IN_CHANNELS*KERNEL_SIZE^2 MAC ops, using a valid/ready handshake. It generates flat element addresses and padding flags, waits for the datapath to retire each result, then asserts done. It sits between the top-level control and the MAC/accumulator unit.

Parameters:
IN_CHANNELS, 3, input channels
IN_HEIGHT, 8, input rows
IN_WIDTH, 8, input columns
OUT_CHANNELS, 4, output channels / filters
KERNEL_SIZE, 3, square kernel side
STRIDE, 1, convolution stride
PADDING, 1, zero padding on each side
OUT_HEIGHT, (IN_HEIGHT+2*PADDING-KERNEL_SIZE)/STRIDE+1, derived output rows
OUT_WIDTH, (IN_WIDTH+2*PADDING-KERNEL_SIZE)/STRIDE+1, derived output columns
IN_AW / W_AW / B_AW / OUT_AW, $clog2 of respective element counts (min 1), address widths

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-low reset (asserted when 0)
start  in  1  begin a layer pass; sampled only in IDLE
busy  out  1  high from the cycle after start is accepted until done
done  out  1  one-cycle pulse when the final output has retired
op_valid  out  1  operand op presented
op_ready  in  1  datapath accepts op when op_valid&&op_ready
op_bias  out  1  op is an accumulator init with bias[b_addr]
op_last  out  1  final MAC op of the current output element
op_pad  out  1  input tap lies in the padding; datapath uses operand 0
in_addr  out  IN_AW  flat input index ic*IH*IW+ih*IW+iw; 0 when op_pad
w_addr  out  W_AW  flat weight index ((oc*IC+ic)*K+kh)*K+kw
b_addr  out  B_AW  bias index = oc
out_addr  out  OUT_AW  flat output index (oc*OH+oh)*OW+ow, held stable per element
res_done  in  1  datapath pulse: result for out_addr written

Behaviour:
- Reset (rst=0, async): state IDLE; all counters 0; busy, done, op_valid, op_bias, op_last, op_pad = 0; all addresses 0.
- States: IDLE -> BIAS -> MAC -> WAIT -> (BIAS | FINISH) -> IDLE.
- IDLE: start=1 -> BIAS next cycle; busy=1 and counters cleared.
- BIAS: op_valid=1, op_bias=1, b_addr=oc. On handshake -> MAC with ic=kh=kw=0.
- MAC: op_valid=1, op_bias=0. ih = oh*STRIDE+kh-PADDING and iw = ow*STRIDE+kw-PADDING, computed signed. op_pad=1 if ih<0, ih>=IH, iw<0 or iw>=IW. The inner loop order is kw fastest, then kh, then ic. op_last=1 when ic=IC-1, kh=kw=K-1. A handshake on the last op -> WAIT.
- Stall: while op_valid&&!op_ready, every op_* field and every address holds stable. op_valid never deasserts without a handshake.
- WAIT: op_valid=0. Stay until res_done=1. Then advance ow, then oh, then oc (ow fastest). If the element just retired was the last one (oc=OC-1, oh=OH-1, ow=OW-1) -> FINISH; otherwise -> BIAS.
- FINISH: done=1 for exactly one cycle, busy=0 in that same cycle, -> IDLE.
- start while busy: ignored. res_done outside WAIT: ignored. A start arriving in the FINISH cycle is ignored.
- Reset mid-pass: immediate abort to IDLE; no done pulse.
- Ops per element: 1 + IC*K*K. Total handshakes: OC*OH*OW*(1+IC*K*K).
- Minimum cycles per element with op_ready=1 and res_done arriving 1 cycle after the last op: 1 + IC*K*K + 1.

Decomposition:
- Shared package conv2d_pkg holds the derived geometry constants (OUT_HEIGHT, OUT_WIDTH), the address-width functions, and the state encoding (IDLE, BIAS, MAC, WAIT, FINISH).
- One sub-module is natural: conv2d_tap_addr. It is combinational and maps (oc, ic, oh, ow, kh, kw) to in_addr, w_addr and op_pad. This lets the address and padding math be unit-tested in isolation.

Test Plan:
- Defaults, op_ready=1, res_done 1 cycle after op_last. After start, the first op is bias with b_addr=0. The next op is a MAC with kh=kw=0, where ih=-1: op_pad=1, in_addr=0, w_addr=0.
- Same pass, 5th MAC of element 0 (kh=1, kw=1): op_pad=0, in_addr=0, w_addr=4. 27th MAC: op_last=1, w_addr=26, in_addr=2*64+1*8+1=137.
- Full pass: exactly 256 bias handshakes and 6912 MAC handshakes. out_addr visits 0..255 in order. One done pulse, then busy=0.
- Random op_ready stalls (about 50%): op fields are bit-stable while stalled. The handshake sequence matches the no-stall run exactly.
- STRIDE=2: OH=OW=4. Element out_addr=5 (oh=1, ow=1), tap kh=kw=0 gives ih=iw=1 and in_addr=9. Total outputs = 64.
- Pull rst low while in MAC at element 10: all outputs clear immediately and no done pulse. A fresh start then restarts at out_addr=0.
